// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcode values, the
// state encoding exported on the debug port, and the datapath select
// encodings that the surrounding datapath (including the ALU control unit)
// also decodes.
package ctrl_pkg;

  // Instruction opcodes (instruction register bits [6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Controller states; the 4-bit code is visible on the state debug port
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // ALU operation class, shared with the sibling ALU control unit
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU A operand select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Bundle of every control line driven by the FSM
  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Dispatch target out of DECODE; unsupported opcodes land in HALT
  function automatic state_t decode_target(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LOAD,
      OP_STORE:  nxt = S_MEM_ADDR;
      OP_RTYPE:  nxt = S_EXEC_R;
      OP_ITYPE:  nxt = S_EXEC_I;
      OP_BRANCH: nxt = S_BRANCH;
      default:   nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main controller of a multicycle processor. Sequences fetch, decode,
// execute, memory and write-back steps and drives the datapath control
// lines. The current state is exported for debug.
//
// Memory handshake: mem_read / mem_write form the request; once raised in
// FETCH, MEM_RD or MEM_WR, the request and address select (iord) are held
// unchanged every cycle until mem_ready=1, which completes the access on
// that rising edge. mem_ready is ignored in all other states.
module multicycle_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  logic   illegal_d;
  ctrl_t  ctrl;

  // State and sticky illegal flag; reset is asynchronous so an in-flight
  // access is dropped immediately (outputs decode to all-zero in IDLE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore/Mealy output decode
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctrl      = '0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        // Read instruction at PC and compute PC+4 in parallel
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        if (mem_ready) begin
          // Instruction and PC+4 are only captured in the completing cycle
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = 1'b0;
          state_d       = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch target in ALUOut
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_d        = decode_target(opcode);
        if (decode_target(opcode) == S_HALT) begin
          illegal_d = 1'b1;
        end
      end

      S_MEM_ADDR: begin
        // Effective address = rs1 + immediate
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        // Only loads and stores reach this state
        state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_OP_FUNCT;
        state_d        = S_ALU_WB;
      end

      S_EXEC_I: begin
        // Immediate ALU ops are restricted to add
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_d        = S_ALU_WB;
      end

      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        state_d         = S_FETCH;
      end

      S_BRANCH: begin
        // Compare rs1 - rs2; take the target held in ALUOut when equal
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
        state_d        = S_FETCH;
      end

      S_HALT: begin
        // Absorbing; only reset leaves
        state_d = S_HALT;
      end

      default: begin
        // Unused encodings recover through IDLE
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign ir_write   = ctrl.ir_write;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. The driver applies one
// cycle of inputs at a time and queues the hand-computed control vector
// expected for that cycle; a monitor pops and compares mid-cycle.
module tb_multicycle_control_fsm;

  // Expected vector layout:
  // {state[3:0], pc_write, pc_src, ir_write, iord, mem_read, mem_write,
  //  reg_write, mem_to_reg, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], illegal}
  localparam int W = 19;

  localparam logic [W-1:0] E_IDLE       = {4'd0,  8'b00000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [W-1:0] E_FETCH_WAIT = {4'd1,  8'b00001000, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [W-1:0] E_FETCH_GO   = {4'd1,  8'b10101000, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [W-1:0] E_DECODE     = {4'd2,  8'b00000000, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [W-1:0] E_MEM_ADDR   = {4'd3,  8'b00000000, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [W-1:0] E_MEM_RD     = {4'd4,  8'b00011000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [W-1:0] E_MEM_WB     = {4'd5,  8'b00000011, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [W-1:0] E_MEM_WR     = {4'd6,  8'b00010100, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [W-1:0] E_EXEC_R     = {4'd7,  8'b00000000, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [W-1:0] E_EXEC_I     = {4'd8,  8'b00000000, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [W-1:0] E_ALU_WB     = {4'd9,  8'b00000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [W-1:0] E_BR_TAKEN   = {4'd10, 8'b11000000, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [W-1:0] E_BR_NOT     = {4'd10, 8'b01000000, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [W-1:0] E_HALT       = {4'd11, 8'b00000000, 2'b00, 2'b00, 2'b00, 1'b1};

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           failures;

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  assign obs = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Driver: apply one cycle of inputs and queue that cycle's expected outputs
  task automatic step(input logic [6:0] op, input logic z, input logic rdy,
                      input logic [W-1:0] exp_v, input string nm);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic [W-1:0] got,
                           input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask

  // Scoreboard monitor: compare mid-cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        string        n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check_now(n, obs, e);
        checks++;
        if (mem_read && mem_write) begin
          failures++;
          $display("FAIL rd_wr_exclusive at %s got=11 exp=0x", n);
        end
      end
    end
  end

  // Stimulus
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, release and fetch stall
    step(OP_R, 1'b0, 1'b1, E_IDLE, "in_reset");
    rst_n = 1'b1;
    step(OP_R, 1'b0, 1'b0, E_IDLE, "idle_after_release");
    for (int i = 0; i < 3; i++) step(OP_R, 1'b0, 1'b0, E_FETCH_WAIT, "fetch_stall");

    // R-type, with mem_ready low where it must be ignored
    step(OP_R, 1'b0, 1'b1, E_FETCH_GO, "r_fetch");
    step(OP_R, 1'b0, 1'b0, E_DECODE,   "r_decode");
    step(OP_R, 1'b1, 1'b0, E_EXEC_R,   "r_exec");
    step(OP_R, 1'b0, 1'b0, E_ALU_WB,   "r_wb");

    // I-type
    step(OP_I, 1'b0, 1'b1, E_FETCH_GO, "i_fetch");
    step(OP_I, 1'b0, 1'b1, E_DECODE,   "i_decode");
    step(OP_I, 1'b0, 1'b1, E_EXEC_I,   "i_exec");
    step(OP_I, 1'b0, 1'b1, E_ALU_WB,   "i_wb");

    // Load with two wait cycles in MEM_RD
    step(OP_LD, 1'b0, 1'b1, E_FETCH_GO, "ld_fetch");
    step(OP_LD, 1'b0, 1'b0, E_DECODE,   "ld_decode");
    step(OP_LD, 1'b0, 1'b0, E_MEM_ADDR, "ld_addr");
    step(OP_LD, 1'b0, 1'b0, E_MEM_RD,   "ld_rd_wait1");
    step(OP_LD, 1'b0, 1'b0, E_MEM_RD,   "ld_rd_wait2");
    step(OP_LD, 1'b0, 1'b1, E_MEM_RD,   "ld_rd_done");
    step(OP_LD, 1'b0, 1'b0, E_MEM_WB,   "ld_wb");

    // Store, no wait
    step(OP_ST, 1'b0, 1'b1, E_FETCH_GO, "st_fetch");
    step(OP_ST, 1'b0, 1'b1, E_DECODE,   "st_decode");
    step(OP_ST, 1'b0, 1'b1, E_MEM_ADDR, "st_addr");
    step(OP_ST, 1'b0, 1'b1, E_MEM_WR,   "st_wr");

    // Branch taken then not taken
    step(OP_BR, 1'b0, 1'b1, E_FETCH_GO, "bt_fetch");
    step(OP_BR, 1'b0, 1'b1, E_DECODE,   "bt_decode");
    step(OP_BR, 1'b1, 1'b1, E_BR_TAKEN, "bt_branch");
    step(OP_BR, 1'b1, 1'b1, E_FETCH_GO, "bn_fetch");
    step(OP_BR, 1'b1, 1'b1, E_DECODE,   "bn_decode");
    step(OP_BR, 1'b0, 1'b1, E_BR_NOT,   "bn_branch");

    // Store interrupted by reset while waiting for memory
    step(OP_ST, 1'b0, 1'b1, E_FETCH_GO, "sr_fetch");
    step(OP_ST, 1'b0, 1'b1, E_DECODE,   "sr_decode");
    step(OP_ST, 1'b0, 1'b0, E_MEM_ADDR, "sr_addr");
    opcode    = OP_ST;
    zero      = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(E_MEM_WR);
    name_q.push_back("sr_wr_wait");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("sr_async_reset_vec", obs, E_IDLE);
    checks++;
    if (mem_write !== 1'b0) begin
      failures++;
      $display("FAIL sr_mem_write_drop got=%b exp=0", mem_write);
    end
    @(posedge clk);
    #1;
    step(OP_ST, 1'b0, 1'b1, E_IDLE, "sr_in_reset");
    rst_n = 1'b1;
    step(OP_ST, 1'b0, 1'b1, E_IDLE, "sr_idle");
    step(OP_ST, 1'b0, 1'b0, E_FETCH_WAIT, "sr_refetch");

    // Illegal opcode: HALT absorbs regardless of inputs
    step(OP_BAD, 1'b0, 1'b1, E_FETCH_GO, "ill_fetch");
    step(OP_BAD, 1'b0, 1'b1, E_DECODE,   "ill_decode");
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? OP_R : OP_LD, 1'(i % 2), 1'b1, E_HALT, "ill_halt");
    end
    rst_n = 1'b0;
    step(OP_R, 1'b0, 1'b1, E_IDLE, "ill_in_reset");
    rst_n = 1'b1;
    step(OP_R, 1'b0, 1'b1, E_IDLE, "ill_idle_cleared");
    step(OP_R, 1'b0, 1'b0, E_FETCH_WAIT, "ill_refetch");

    // Let the monitor drain the last entry
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
